// File: rtl/seq_divider_8bit_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// registered results, status flags and handshake out.
interface seq_divider_8bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, op, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, op, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_8bit.sv
// Restoring shift-subtract divider, one quotient bit per cycle, unsigned or
// two's-complement signed (sign fix-up applied to magnitudes after the loop).
module seq_divider_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_8bit_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;

  always_comb begin
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    a_neg   = bus.op & bus.dividend[WIDTH-1];
    b_neg   = bus.op & bus.divisor[WIDTH-1];
    a_mag   = a_neg ? -bus.dividend : bus.dividend;
    b_mag   = b_neg ? -bus.divisor  : bus.divisor;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            acc_d      = a_mag;
            dvs_d      = b_mag;
            rem_d      = '0;
            cnt_d      = '0;
            q_neg_d    = a_neg ^ b_neg;
            r_neg_d    = a_neg;
            ovf_pend_d = bus.op && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         && (bus.divisor == '1);
            busy_d     = 1'b1;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          acc_d = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = q_neg_q ? -acc_q : acc_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        dbz_d       = 1'b0;
        ovf_d       = ovf_pend_q;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider_8bit.sv
// Scoreboard bench for seq_divider_8bit: stimulus pushes arithmetic-model
// results, a negedge monitor pops and compares on every done pulse.
module tb_seq_divider_8bit;
  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  seq_divider_8bit_if #(.WIDTH(8)) bus ();

  seq_divider_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         at;
    int         busy_n;
  } exp_t;

  exp_t scb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic exp_t model(input logic op, input logic [7:0] a,
                                 input logic [7:0] b, input int k);
    exp_t e;
    int   sa, sb, q, r;
    if (b == 8'h00) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.ovf = 1'b0;
      e.at = k; e.busy_n = 0;
    end else begin
      sa = op ? int'($signed(a)) : int'(a);
      sb = op ? int'($signed(b)) : int'(b);
      q  = sa / sb;
      r  = sa % sb;
      e.q = q[7:0]; e.r = r[7:0]; e.dbz = 1'b0;
      e.ovf = op && (sa == -128) && (sb == -1);
      e.at = k + 9; e.busy_n = 9;
    end
    return e;
  endfunction

  // Monitor
  int         busy_run;
  logic       prev_done;
  logic [7:0] last_q, last_r;
  logic       last_dbz, last_ovf;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0; prev_done = 1'b0;
      last_q = '0; last_r = '0; last_dbz = 1'b0; last_ovf = 1'b0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        chk("done_width", int'(prev_done), 0);
        chk("busy_in_done", int'(bus.busy), 0);
        if (scb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = scb.pop_front();
          chk("quotient", int'(bus.quotient), int'(e.q));
          chk("remainder", int'(bus.remainder), int'(e.r));
          chk("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
          chk("overflow", int'(bus.overflow), int'(e.ovf));
          chk("done_cycle", cyc, e.at);
          chk("busy_cycles", busy_run, e.busy_n);
        end
        busy_run = 0;
        last_q = bus.quotient; last_r = bus.remainder;
        last_dbz = bus.div_by_zero; last_ovf = bus.overflow;
      end else begin
        chk("hold_results", int'({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}),
            int'({last_q, last_r, last_dbz, last_ovf}));
      end
      prev_done = bus.done;
    end
  end

  task automatic launch(input logic op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    scb.push_back(model(op, a, b, cyc));
    @(negedge clk);
    bus.start = 1'b0; bus.op = 1'($urandom);
    bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (scb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", scb.size(), 0);
    scb.delete();
  endtask

  task automatic chk_zero_outputs(input string name);
    chk(name, int'({bus.quotient, bus.remainder, bus.busy, bus.done,
                    bus.div_by_zero, bus.overflow}), 0);
  endtask

  typedef struct { logic op; logic [7:0] a; logic [7:0] b; } vec_t;
  vec_t dir[8] = '{
    '{1'b0, 8'hC8, 8'h07}, '{1'b1, 8'h9C, 8'h07}, '{1'b1, 8'h64, 8'hF9},
    '{1'b0, 8'h37, 8'h00}, '{1'b1, 8'h80, 8'hFF}, '{1'b1, 8'h80, 8'h00},
    '{1'b0, 8'hFF, 8'h01}, '{1'b1, 8'h7F, 8'h80}
  };

  initial begin
    int k;
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset_state");
    #2 rst_n = 1'b1;

    foreach (dir[i]) begin
      launch(dir[i].op, dir[i].a, dir[i].b);
      drain(30);
    end

    // start pulsed on the 3rd RUN cycle must be ignored
    launch(1'b0, 8'hC8, 8'h07);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.dividend = 8'h11; bus.divisor = 8'h03;
    @(negedge clk);
    bus.start = 1'b0;
    drain(30);

    // start held high: a new division every time IDLE is reached
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.dividend = 8'hC8; bus.divisor = 8'h07;
    @(posedge clk); #1;
    k = cyc;
    for (int n = 0; n < 3; n++) scb.push_back(model(1'b0, 8'hC8, 8'h07, k + 11 * n));
    for (int i = 0; i < 40; i++) begin
      if (cyc >= k + 22) break;
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain(40);

    // reset on the 4th RUN cycle aborts with no done pulse
    launch(1'b0, 8'hC8, 8'h07);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    scb.delete();
    #1 chk_zero_outputs("reset_abort_immediate");
    @(negedge clk);
    chk_zero_outputs("reset_abort_held");
    #2 rst_n = 1'b1;
    launch(1'b0, 8'hFF, 8'h10);
    drain(30);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      launch(1'($urandom), 8'($urandom), b);
      drain(30);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
